// File: rtl/mem_responder_if.sv
// ============================================================================
//  Module : mem_responder_if
//  Shared memory bus between the instruction/data selector and the responder.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

interface mem_responder_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [DATA_WIDTH-1:0] mem_write_val;
    logic [DATA_WIDTH-1:0] mem_read_val;

    modport master (
        output mem_addr, mem_read_en, mem_write_en, mem_write_val,
        input  mem_read_val
    );

    modport slave (
        input  mem_addr, mem_read_en, mem_write_en, mem_write_val,
        output mem_read_val
    );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
//  Module : mem_responder
//  2^ADDR_WIDTH x DATA_WIDTH memory serving the shared bus, preceded by a
//  byte-serial little-endian program loader that holds the CPU stopped.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    mem_responder_if.slave             bus,
    input  wire logic                  load_byte_valid,
    input  wire logic [7:0]            load_byte,
    input  wire logic                  load_done,
    output logic                       load_ready,
    output logic                       cpu_run,
    output logic [ADDR_WIDTH:0]        load_count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_WIDTH:0] c_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [0:0] {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                r_state;
    logic                  r_load_ready;
    logic                  r_cpu_run;
    logic [ADDR_WIDTH:0]   r_load_count;
    logic [IDX_W-1:0]      r_byte_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  w_accept;
    logic                  w_last;
    logic [ADDR_WIDTH:0]   w_count_inc;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;

    assign w_accept    = load_byte_valid & r_load_ready & (r_state == ST_LOAD);
    assign w_last      = (r_byte_idx == IDX_W'(BYTES - 1));
    assign w_count_inc = r_load_count + (ADDR_WIDTH+1)'(1);

    // Byte i of a word lands in bits [8*i+7:8*i]: first byte is the LSB.
    always_comb begin
        w_shift_next = r_shift;
        for (int b = 0; b < BYTES; b++) begin
            if (r_byte_idx == IDX_W'(b)) begin
                w_shift_next[8*b +: 8] = load_byte;
            end
        end
    end

    // One RAM write port shared by the loader (LOAD) and the bus (RUN).
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = bus.mem_addr;
        w_ram_wdata = bus.mem_write_val;
        if (!rst) begin
            if (r_state == ST_LOAD) begin
                w_ram_we    = w_accept & w_last;
                w_ram_addr  = r_load_count[ADDR_WIDTH-1:0];
                w_ram_wdata = w_shift_next;
            end else begin
                w_ram_we    = bus.mem_write_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_LOAD;
            r_load_ready <= 1'b1;
            r_cpu_run    <= 1'b0;
            r_load_count <= '0;
            r_byte_idx   <= '0;
            r_shift      <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_load_count <= w_count_inc;
                            r_byte_idx   <= '0;
                            r_shift      <= '0;
                            if (w_count_inc == c_FULL) begin
                                r_state      <= ST_RUN;
                                r_load_ready <= 1'b0;
                                r_cpu_run    <= 1'b1;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + IDX_W'(1);
                            r_shift    <= w_shift_next;
                        end
                    end
                    // A word completing on this edge is committed above first;
                    // any partial word is simply dropped.
                    if (load_done) begin
                        r_state      <= ST_RUN;
                        r_load_ready <= 1'b0;
                        r_cpu_run    <= 1'b1;
                        r_byte_idx   <= '0;
                        r_shift      <= '0;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.mem_read_val = ((r_state == ST_RUN) && bus.mem_read_en) ?
                              r_mem[bus.mem_addr] : '0;
    assign load_ready = r_load_ready;
    assign cpu_run    = r_cpu_run;
    assign load_count = r_load_count;

endmodule

`default_nettype wire
